// File: rtl/seq_feeder.sv
// Feeds query chunks and the target stream to an N-PE systolic array.
// Bases are loaded into local buffers while idle, then streamed chunk by chunk.
module seq_feeder #(
    parameter int N        = 4,
    parameter int BP_WIDTH = 2,
    parameter int Q_DEPTH  = 64,
    parameter int T_DEPTH  = 256,
    parameter int LEN_W    = 9
) (
    input  logic                clk,
    input  logic                reset_i,
    input  logic                ld_en,
    input  logic                ld_sel,
    input  logic [LEN_W-1:0]    ld_addr,
    input  logic [BP_WIDTH-1:0] ld_data,
    input  logic                start,
    input  logic [LEN_W-1:0]    q_len,
    input  logic [LEN_W-1:0]    t_len,
    input  logic                busy,
    output logic [BP_WIDTH-1:0] S,
    output logic [BP_WIDTH-1:0] T,
    output logic                s_update,
    output logic                valid,
    output logic                ack,
    output logic                new_seq,
    output logic                done,
    output logic [LEN_W-1:0]    chunk_idx,
    output logic [2:0]          dbg_state
);

    localparam int QA_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int TA_W = (T_DEPTH > 1) ? $clog2(T_DEPTH) : 1;
    localparam logic [LEN_W-1:0] Q_MAX = LEN_W'(Q_DEPTH);
    localparam logic [LEN_W-1:0] T_MAX = LEN_W'(T_DEPTH);
    localparam logic [LEN_W-1:0] N_L   = LEN_W'(N);
    localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

    typedef enum logic [2:0] {
        IDLE, KICK, LOAD_S, STREAM_T, WAIT_HI, WAIT_LO, FIN
    } state_t;

    state_t state;

    logic [BP_WIDTH-1:0] q_mem [Q_DEPTH];
    logic [BP_WIDTH-1:0] t_mem [T_DEPTH];

    logic [LEN_W-1:0]    q_len_r;
    logic [LEN_W-1:0]    t_len_r;
    logic [LEN_W-1:0]    nchunk;
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    q_sat;
    logic [LEN_W-1:0]    t_sat;
    logic [LEN_W-1:0]    q_addr;
    logic [LEN_W-1:0]    chunk_next;
    logic [BP_WIDTH-1:0] q_rd;
    logic [BP_WIDTH-1:0] t_rd;

    assign dbg_state = state;

    always_comb begin
        q_sat      = (q_len > Q_MAX) ? Q_MAX : q_len;
        t_sat      = (t_len > T_MAX) ? T_MAX : t_len;
        chunk_next = chunk_idx + ONE;
        q_addr     = chunk_idx * N_L + cnt;
        // Slots past the query end of the last chunk are zero padding.
        q_rd       = (q_addr < q_len_r) ? q_mem[q_addr[QA_W-1:0]] : '0;
        t_rd       = t_mem[cnt[TA_W-1:0]];
    end

    // Buffers are not reset so their contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && ld_en) begin
            if (!ld_sel && ld_addr < Q_MAX) q_mem[ld_addr[QA_W-1:0]] <= ld_data;
            if (ld_sel && ld_addr < T_MAX)  t_mem[ld_addr[TA_W-1:0]] <= ld_data;
        end
    end

    // busy handshake: after each chunk the array raises busy while it works and
    // drops it when finished; the next chunk is kicked only after a full 1->0.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            S         <= '0;
            T         <= '0;
            s_update  <= 1'b0;
            valid     <= 1'b0;
            ack       <= 1'b0;
            new_seq   <= 1'b0;
            done      <= 1'b0;
            chunk_idx <= '0;
            q_len_r   <= '0;
            t_len_r   <= '0;
            nchunk    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_len_r   <= q_sat;
                        t_len_r   <= t_sat;
                        nchunk    <= (q_sat + N_L - ONE) / N_L;
                        cnt       <= '0;
                        chunk_idx <= '0;
                        if (q_sat == '0 || t_sat == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state   <= KICK;
                            ack     <= 1'b1;
                            new_seq <= 1'b1;
                        end
                    end
                end
                KICK: begin
                    ack      <= 1'b0;
                    new_seq  <= 1'b0;
                    s_update <= 1'b1;
                    S        <= q_rd;
                    cnt      <= ONE;
                    state    <= LOAD_S;
                end
                LOAD_S: begin
                    if (cnt == N_L) begin
                        s_update <= 1'b0;
                        valid    <= 1'b1;
                        T        <= t_mem[0];
                        cnt      <= ONE;
                        state    <= STREAM_T;
                    end else begin
                        S   <= q_rd;
                        cnt <= cnt + ONE;
                    end
                end
                STREAM_T: begin
                    if (cnt == t_len_r) begin
                        valid <= 1'b0;
                        cnt   <= '0;
                        state <= WAIT_HI;
                    end else begin
                        T   <= t_rd;
                        cnt <= cnt + ONE;
                    end
                end
                WAIT_HI: begin
                    if (busy) state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!busy) begin
                        chunk_idx <= chunk_next;
                        if (chunk_next < nchunk) begin
                            state <= KICK;
                            ack   <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    done      <= 1'b0;
                    chunk_idx <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_feeder.sv
// Directed bench for seq_feeder: event-list model of each run plus per-cycle
// compare process and hand-computed literal expectations.
module tb_seq_feeder;
  localparam int N   = 4;
  localparam int BPW = 2;
  localparam int QD  = 64;
  localparam int TD  = 256;
  localparam int LW  = 9;

  logic           clk;
  logic           reset_i;
  logic           ld_en;
  logic           ld_sel;
  logic [LW-1:0]  ld_addr;
  logic [BPW-1:0] ld_data;
  logic           start;
  logic [LW-1:0]  q_len;
  logic [LW-1:0]  t_len;
  logic           busy;
  logic [BPW-1:0] S;
  logic [BPW-1:0] T;
  logic           s_update;
  logic           valid;
  logic           ack;
  logic           new_seq;
  logic           done;
  logic [LW-1:0]  chunk_idx;
  logic [2:0]     dbg_state;

  seq_feeder #(.N(N), .BP_WIDTH(BPW), .Q_DEPTH(QD), .T_DEPTH(TD), .LEN_W(LW)) dut (
    .clk(clk), .reset_i(reset_i), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .start(start), .q_len(q_len), .t_len(t_len), .busy(busy),
    .S(S), .T(T), .s_update(s_update), .valid(valid), .ack(ack), .new_seq(new_seq),
    .done(done), .chunk_idx(chunk_idx), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [BPW-1:0]    q_model [QD];
  logic [BPW-1:0]    t_model [TD];
  logic [LW+BPW-1:0] exp_s_q[$];
  logic [BPW-1:0]    exp_t_q[$];
  logic [LW:0]       exp_ack_q[$];
  int                exp_done = 0;
  logic [BPW-1:0]    last_s, last_t;
  logic [LW+BPW-1:0] e_s;
  logic [BPW-1:0]    e_t;
  logic [LW:0]       e_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic load(input logic sel, input int addr, input logic [BPW-1:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_addr = LW'(addr); ld_data = d;
    tick();
    ld_en = 1'b0;
    if (!sel && addr < QD) q_model[addr] = d;
    if (sel && addr < TD)  t_model[addr] = d;
  endtask

  task automatic build_expect(input int ql, input int tl, output int nch);
    int qs, ts, idx;
    logic [BPW-1:0] v;
    qs = (ql > QD) ? QD : ql;
    ts = (tl > TD) ? TD : tl;
    nch = 0;
    if (qs != 0 && ts != 0) begin
      nch = (qs + N - 1) / N;
      for (int c = 0; c < nch; c++) begin
        exp_ack_q.push_back({(c == 0), LW'(c)});
        for (int k = 0; k < N; k++) begin
          idx = c * N + k;
          v = (idx < qs) ? q_model[idx] : '0;
          exp_s_q.push_back({LW'(c), v});
        end
        for (int j = 0; j < ts; j++) exp_t_q.push_back(t_model[j]);
      end
    end
    exp_done++;
  endtask

  task automatic pulse_start(input int ql, input int tl);
    q_len = LW'(ql); t_len = LW'(tl); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic serve_chunk(input int hold_lo, input bit inject);
    int b;
    logic [2:0] st0;
    b = 0;
    while (!valid && b < 50) begin tick(); b++; end
    chk("valid_rise_timeout", valid, 1);
    if (inject) begin
      q_len = LW'(1); t_len = LW'(1); start = 1'b1;
      tick();
      start = 1'b0;
      chk("stream_after_stray_start", valid, 1);
    end
    b = 0;
    while (valid && b < 400) begin tick(); b++; end
    chk("valid_fall_timeout", valid, 0);
    if (inject) begin
      ld_en = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = ~q_model[0];
      tick();
      ld_sel = 1'b1; ld_data = ~t_model[0];
      tick();
      ld_en = 1'b0;
    end
    st0 = dbg_state;
    for (int i = 0; i < hold_lo; i++) begin
      tick();
      if (hold_lo >= 20) begin
        chk("wait_hi_stays", dbg_state, st0);
        chk("no_ack_in_wait", ack, 0);
      end
    end
    busy = 1'b1;
    repeat (2) tick();
    busy = 1'b0;
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (!done && b < 60) begin tick(); b++; end
    chk("done_seen", done, 1);
    tick();
    chk("done_one_cycle", done, 0);
    chk("chunk_idx_idle", chunk_idx, 0);
    chk("exp_s_drained", exp_s_q.size(), 0);
    chk("exp_t_drained", exp_t_q.size(), 0);
    chk("exp_ack_drained", exp_ack_q.size(), 0);
    chk("exp_done_drained", exp_done, 0);
  endtask

  task automatic run(input int ql, input int tl, input int hold_lo, input bit inject);
    int nch;
    build_expect(ql, tl, nch);
    pulse_start(ql, tl);
    for (int c = 0; c < nch; c++) serve_chunk(hold_lo, inject && c == 0);
    wait_done();
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    if (!reset_i) begin
      last_s = '0;
      last_t = '0;
    end else begin
      chk("strobes_exclusive", 32'(s_update) + 32'(valid) + 32'(ack) + 32'(done) <= 32'd1, 1);
      if (s_update) begin
        chk("s_update_expected", exp_s_q.size() > 0, 1);
        if (exp_s_q.size() > 0) begin
          e_s = exp_s_q.pop_front();
          chk("S", S, e_s[BPW-1:0]);
          chk("chunk_idx_load", chunk_idx, e_s[LW+BPW-1:BPW]);
        end
      end else chk("S_hold", S, last_s);
      if (valid) begin
        chk("valid_expected", exp_t_q.size() > 0, 1);
        if (exp_t_q.size() > 0) begin
          e_t = exp_t_q.pop_front();
          chk("T", T, e_t);
        end
      end else chk("T_hold", T, last_t);
      if (ack) begin
        chk("ack_expected", exp_ack_q.size() > 0, 1);
        if (exp_ack_q.size() > 0) begin
          e_a = exp_ack_q.pop_front();
          chk("new_seq", new_seq, e_a[LW]);
          chk("chunk_idx_kick", chunk_idx, e_a[LW-1:0]);
        end
      end else chk("new_seq_without_ack", new_seq, 0);
      if (done) begin
        chk("done_expected", exp_done > 0, 1);
        if (exp_done > 0) exp_done--;
      end
      last_s = S;
      last_t = T;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nch;
    logic [LW+BPW-1:0] tmp;
    logic [BPW-1:0] lit_s [4];
    logic [BPW-1:0] lit_t [3];
    reset_i = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; q_len = '0; t_len = '0; busy = 1'b0;
    repeat (2) tick();
    chk("rst_S", S, 0);
    chk("rst_T", T, 0);
    chk("rst_strobes", {s_update, valid, ack, new_seq, done}, 0);
    chk("rst_chunk_idx", chunk_idx, 0);
    reset_i = 1'b1;
    tick();

    for (int i = 0; i < QD; i++) load(1'b0, i, BPW'($urandom_range(0, 3)));
    for (int i = 0; i < TD; i++) load(1'b1, i, BPW'($urandom_range(0, 3)));

    // single chunk, cycle-exact literal walk
    for (int i = 0; i < 4; i++) load(1'b0, i, BPW'(i));
    load(1'b1, 0, 2'd3); load(1'b1, 1, 2'd2); load(1'b1, 2, 2'd1);
    lit_s = '{2'd0, 2'd1, 2'd2, 2'd3};
    lit_t = '{2'd3, 2'd2, 2'd1};
    build_expect(4, 3, nch);
    chk("model_nchunk_1", nch, 1);
    for (int k = 0; k < 4; k++) begin tmp = exp_s_q[k]; chk("model_s_lit", tmp[BPW-1:0], lit_s[k]); end
    for (int j = 0; j < 3; j++) chk("model_t_lit", exp_t_q[j], lit_t[j]);
    pulse_start(4, 3);
    chk("t1_ack", ack, 1);
    chk("t1_new_seq", new_seq, 1);
    chk("t1_chunk_idx", chunk_idx, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_s_update", s_update, 1);
      chk("t1_S", S, lit_s[k]);
      chk("t1_ack_low", ack, 0);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("t1_valid", valid, 1);
      chk("t1_T", T, lit_t[j]);
      chk("t1_s_update_low", s_update, 0);
    end
    tick();
    chk("t1_valid_end", valid, 0);
    busy = 1'b1; repeat (2) tick(); busy = 1'b0;
    wait_done();

    // two chunks with zero padding
    load(1'b0, 4, 2'd2); load(1'b0, 5, 2'd1); load(1'b0, 6, 2'd3); load(1'b0, 7, 2'd3);
    build_expect(6, 5, nch);
    chk("model_nchunk_2", nch, 2);
    chk("model_ack0", exp_ack_q[0], {1'b1, LW'(0)});
    chk("model_ack1", exp_ack_q[1], {1'b0, LW'(1)});
    lit_s = '{2'd2, 2'd1, 2'd0, 2'd0};
    for (int k = 0; k < 4; k++) chk("model_pad_lit", exp_s_q[4 + k], {LW'(1), lit_s[k]});
    pulse_start(6, 5);
    for (int c = 0; c < 2; c++) serve_chunk(3, 1'b0);
    wait_done();

    // zero-length runs go straight to done
    build_expect(5, 0, nch);
    pulse_start(5, 0);
    chk("t0_done_next_cycle", done, 1);
    chk("t0_no_ack", ack, 0);
    wait_done();
    run(0, 7, 2, 1'b0);

    // out-of-range writes must not alias onto low addresses
    load(1'b0, 64, ~q_model[0]);
    load(1'b1, 256, ~t_model[0]);
    load(1'b1, 5, 2'd2);
    // stray start in STREAM_T and stray writes in WAIT_HI, then readback
    run(4, 6, 2, 1'b1);
    run(4, 6, 2, 1'b0);

    // asynchronous reset in the 2nd LOAD_S cycle
    build_expect(6, 2, nch);
    pulse_start(6, 2);
    tick();
    tick();
    chk("pre_reset_s_update", s_update, 1);
    reset_i = 1'b0;
    exp_s_q.delete(); exp_t_q.delete(); exp_ack_q.delete(); exp_done = 0;
    #1;
    chk("async_rst_S", S, 0);
    chk("async_rst_strobes", {s_update, valid, ack, new_seq, done}, 0);
    chk("async_rst_chunk_idx", chunk_idx, 0);
    tick(); tick();
    reset_i = 1'b1;
    tick();
    run(6, 2, 2, 1'b0);

    // long busy-low hold in WAIT_HI
    run(3, 2, 20, 1'b0);

    // length saturation at the buffer depths
    run(70, 260, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
